ssd_scan_mux: RTL and testbench
===============================

# ssd_scan_mux

Parametrised multiplexed seven-segment display driver. It time-multiplexes DIGITS hex digits onto one shared active-low segment bus, one digit at a time. Between digits it inserts a dead-time blanking interval to suppress ghosting. It also offers tear-free frame loading, leading-zero suppression, per-digit blanking and decimal points. It sits between the counter/stopwatch logic and the board anode/segment pins. It is the successor to the fixed 4-digit, always-hex scan logic.

## Interface
- DIGITS, 4: number of digits/anodes, 1..8.
- CLK_DIV, 1250: clock cycles per digit slot (blank + on), ≥ 2.
- BLANK_CYCLES, 16: dead-time cycles at the start of each slot, 0..CLK_DIV-1.
- x1  in  1: system clock; all logic on its rising edge.
- rst  in  1: asynchronous, active-high reset.
- enable  in  1: 1 = scanning; 0 = display dark.
- load  in  1: one-cycle strobe; captures digits_in/dp_in/blank_mask into the pending register.
- digits_in  in  4*DIGITS: digit k = bits [4k+3:4k]; digit 0 is rightmost and least significant.
- dp_in  in  DIGITS: decimal point request per digit.
- blank_mask  in  DIGITS: 1 forces segments a–g of that digit off.
- lz_blank  in  1: 1 enables leading-zero suppression.
- anodes  out  DIGITS: active-low digit enables.
- segments  out  8: active-low; bit 7 = DP, bits 6:0 = g..a.
- frame_done  out  1: one-cycle pulse at the end of the last digit's slot.

## Operation
- The FSM has three states:
  - IDLE: all anodes 1, segments 8'hFF.
  - BLANK: all anodes 1, segments 8'hFF.
  - ON: anodes[idx] = 0, all other anodes 1, segments = encoded digit idx.
- Slot counter cnt runs 0..CLK_DIV-1 within each slot, with idx = 0..DIGITS-1:
  - BLANK occupies cnt 0..BLANK_CYCLES-1.
  - ON occupies cnt BLANK_CYCLES..CLK_DIV-1.
  - If BLANK_CYCLES = 0, BLANK is never entered.
- At cnt = CLK_DIV-1, cnt wraps to 0 and idx increments, wrapping from DIGITS-1 to 0.
  - frame_done pulses on the cycle after the wrap from DIGITS-1.
- Frame boundary (entry to slot 0): the shadow register takes the pending register's value. Only the shadow register drives the display, so a frame never mixes old and new data.
- load on the same cycle as the boundary: the boundary copies the old pending value; the new data reaches the pending register and is displayed from the next frame.
- Segment encode: hex 0–F use the shared codes (0 = 8'hC0, 1 = 8'hF9, 8 = 8'h80, A = 8'h88, F = 8'h8E). Bit 7 is then overridden to ~dp.
- Leading-zero suppression: digit k (k ≥ 1) is blanked when lz_blank = 1 and digits k..DIGITS-1 are all 0. Digit 0 is never suppressed.
- A blanked digit (LZ or blank_mask) drives bits 6:0 = 1. Its DP still follows dp_in.
- enable falling: next edge enters IDLE, outputs go dark, cnt and idx clear to 0.
- enable rising: next edge starts slot 0 at cnt 0 (BLANK, or ON if BLANK_CYCLES = 0), with a frame-boundary shadow update.

## Timing
- Reset values:
  - anodes all 1, segments 8'hFF, frame_done 0.
  - State IDLE; cnt, idx, pending and shadow all 0.
- After reset deassert with enable = 1, the first edge enters slot 0.
- All outputs are registered and change on the same edge as the state/cnt update. There are no combinational paths from inputs to outputs.
- Per-digit ON time is CLK_DIV-BLANK_CYCLES cycles. Frame period is DIGITS*CLK_DIV cycles. At 100 MHz with the defaults this gives a 20 kHz frame.
- Data latency from a load strobe to the pins is at least 1 cycle plus the time to the next frame boundary, at most DIGITS*CLK_DIV+1 cycles.
- rst asserted mid-slot forces the reset values immediately (asynchronous). The pending value is lost.
- enable low during a load: pending still captures. It is applied on the boundary taken when enable next rises.

## Structure
- Package ssd_pkg:
  - 16-entry hex-to-segment constant array.
  - SEG_OFF = 8'hFF.
  - FSM state enum {IDLE, BLANK, ON}.
- Sub-module ssd_hex_decode: purely combinational. Maps 4-bit value, blank and dp to 8-bit segments. It is reused by other display blocks.
- Top level holds the FSM, cnt/idx counters, pending/shadow registers and the LZ detection chain.

## Test plan
- Reset and defaults: DIGITS = 4, CLK_DIV = 8, BLANK_CYCLES = 2, load 16'h12AF with enable = 1. Check that each frame shows anodes 1110/F, 1101/A, 1011/2, 0111/1. Each digit is ON for 6 cycles after 2 dark cycles, and frame_done pulses every 32 cycles.
- Leading-zero suppression: load 16'h0005 with lz_blank = 1. Digits 3..1 drive segments 8'hFF while their anode is low; digit 0 drives 8'h92. With lz_blank = 0, digits 3..1 drive 8'hC0.
- Mask and decimal point: blank_mask = 4'b0100, dp_in = 4'b0100. Digit 2 drives 8'h7F.
- Tear-free load: load 16'h1111, then 16'h2222 mid-frame. The rest of the current frame shows 1 (8'hF9); the next frame shows 2 on all digits. Also strobe load exactly on the boundary cycle and check the new value is delayed by one frame.
- Enable and reset: drop enable mid-ON. Next cycle anodes = 4'hF and segments = 8'hFF. Re-raise enable and check the restart at slot 0 with cnt 0. Assert rst mid-slot and check outputs go dark without waiting for a clock edge.
- BLANK_CYCLES = 0 and DIGITS = 1: anodes[0] is held low continuously, and frame_done pulses every CLK_DIV cycles.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared seven-segment constants and the scan FSM state type.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ssd_pkg;

  // All segments dark (active-low bus).
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low hex glyphs, bit 7 = DP (off here), bits 6:0 = g..a.
  localparam logic [7:0] HEX_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

endpackage

// File: rtl/ssd_hex_decode.sv
// Hex nibble to active-low seven-segment pattern with blank and decimal point.
// Latency: purely combinational.
// Backpressure: none.
module ssd_hex_decode
  import ssd_pkg::*;
(
  input  logic [3:0] val,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] seg
);

  // Blanking kills only a..g; the decimal point is always honoured.
  always_comb begin
    seg = {~dp, blank ? 7'h7F : HEX_SEG[val][6:0]};
  end

endmodule

// File: rtl/ssd_scan_mux.sv
// Time-multiplexed seven-segment scanner with dead-time, tear-free frames and LZ blanking.
// Latency: load reaches the pins at the next frame boundary (1 .. DIGITS*CLK_DIV+1 cycles).
// Backpressure: none; load is a fire-and-forget strobe and is never stalled.
module ssd_scan_mux
  import ssd_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int CLK_DIV      = 1250,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  x1,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  lz_blank,
  output logic [DIGITS-1:0]     anodes,
  output logic [7:0]            segments,
  output logic                  frame_done
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  typedef struct packed {
    logic [4*DIGITS-1:0] dig;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   mask;
  } frame_t;

  state_t          state, nxt_state;
  logic [CW-1:0]   cnt, nxt_cnt;
  logic [IW-1:0]   idx, nxt_idx;
  frame_t          pending, shadow, nxt_shadow;
  logic            wrap_last;
  logic [DIGITS-1:0] lz_zero;
  logic            lz_run;
  logic [3:0]      cur_val;
  logic            cur_dp;
  logic            cur_blank;
  logic [7:0]      dec_seg;

  // Next slot position; the shadow copy is taken on every entry to slot 0.
  always_comb begin
    nxt_state  = state;
    nxt_cnt    = cnt;
    nxt_idx    = idx;
    nxt_shadow = shadow;
    wrap_last  = 1'b0;
    if (!enable) begin
      nxt_state = IDLE;
      nxt_cnt   = '0;
      nxt_idx   = '0;
    end else if (state == IDLE) begin
      nxt_cnt    = '0;
      nxt_idx    = '0;
      nxt_shadow = pending;
      nxt_state  = (BLANK_CYCLES > 0) ? BLANK : ON;
    end else begin
      if (cnt == CNT_LAST) begin
        nxt_cnt = '0;
        if (idx == IDX_LAST) begin
          nxt_idx    = '0;
          nxt_shadow = pending;
          wrap_last  = 1'b1;
        end else begin
          nxt_idx = idx + 1'b1;
        end
      end else begin
        nxt_cnt = cnt + 1'b1;
      end
      nxt_state = (int'(nxt_cnt) < BLANK_CYCLES) ? BLANK : ON;
    end
  end

  // Leading-zero chain from the top digit down, then pick the digit being shown next.
  always_comb begin
    lz_run    = 1'b1;
    lz_zero   = '0;
    cur_val   = 4'd0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      lz_run     = lz_run & (nxt_shadow.dig[4*k +: 4] == 4'd0);
      lz_zero[k] = lz_run;
    end
    for (int k = 0; k < DIGITS; k++) begin
      if (nxt_idx == IW'(k)) begin
        cur_val   = nxt_shadow.dig[4*k +: 4];
        cur_dp    = nxt_shadow.dp[k];
        cur_blank = nxt_shadow.mask[k] | (lz_blank & lz_zero[k] & (k != 0));
      end
    end
  end

  ssd_hex_decode u_dec (
    .val   (cur_val),
    .blank (cur_blank),
    .dp    (cur_dp),
    .seg   (dec_seg)
  );

  // State, counters, frame registers and registered pin drivers.
  always_ff @(posedge x1 or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      pending    <= '0;
      shadow     <= '0;
      anodes     <= '1;
      segments   <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      idx        <= nxt_idx;
      shadow     <= nxt_shadow;
      frame_done <= wrap_last;
      if (load) begin
        pending <= '{dig: digits_in, dp: dp_in, mask: blank_mask};
      end
      if (nxt_state == ON) begin
        anodes   <= ~(DIGITS'(1) << nxt_idx);
        segments <= dec_seg;
      end else begin
        anodes   <= '1;
        segments <= SEG_OFF;
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Scoreboard bench for ssd_scan_mux (4-digit instance plus a 1-digit, no-dead-time instance).
// Latency: n/a.
// Backpressure: n/a.
module tb_ssd_scan_mux;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
    logic       fd;
  } exp_t;

  logic        x1;
  logic        rst;
  logic        enable, load, lz_blank;
  logic [15:0] digits_in;
  logic [3:0]  dp_in, blank_mask;
  logic [3:0]  anodes;
  logic [7:0]  segments;
  logic        frame_done;

  logic        en2, load2, lz2;
  logic [3:0]  dig2;
  logic        dp2, mask2;
  logic        an2;
  logic [7:0]  seg2;
  logic        fd2;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q[$];

  logic [7:0] hex_tbl [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  ssd_scan_mux #(.DIGITS(4), .CLK_DIV(8), .BLANK_CYCLES(2)) dut (
    .x1(x1), .rst(rst), .enable(enable), .load(load),
    .digits_in(digits_in), .dp_in(dp_in), .blank_mask(blank_mask), .lz_blank(lz_blank),
    .anodes(anodes), .segments(segments), .frame_done(frame_done)
  );

  ssd_scan_mux #(.DIGITS(1), .CLK_DIV(5), .BLANK_CYCLES(0)) dut2 (
    .x1(x1), .rst(rst), .enable(en2), .load(load2),
    .digits_in(dig2), .dp_in(dp2), .blank_mask(mask2), .lz_blank(lz2),
    .anodes(an2), .segments(seg2), .frame_done(fd2)
  );

  initial x1 = 1'b0;
  always #5 x1 = ~x1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, act, exp);
    end
  endtask

  // One full frame of expected pin states, starting at slot 0 cnt 0.
  task automatic push_frame(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] mask,
                            input logic lz, input logic fd0);
    exp_t        e;
    logic [3:0]  v;
    logic [15:0] upper;
    logic        blk;
    for (int k = 0; k < 4; k++) begin
      v     = d[4*k +: 4];
      upper = d >> (4*k);
      blk   = mask[k] || (lz && (k >= 1) && (upper == 16'h0000));
      for (int c = 0; c < 8; c++) begin
        e.fd = (k == 0 && c == 0) ? fd0 : 1'b0;
        if (c < 2) begin
          e.an  = 4'hF;
          e.seg = 8'hFF;
        end else begin
          e.an  = 4'hF;
          e.an[k] = 1'b0;
          e.seg = {~dp[k], blk ? 7'h7F : hex_tbl[v][6:0]};
        end
        q.push_back(e);
      end
    end
  endtask

  task automatic push_dark(input int n);
    exp_t e;
    e.an  = 4'hF;
    e.seg = 8'hFF;
    e.fd  = 1'b0;
    for (int i = 0; i < n; i++) q.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(negedge x1);
    if (q.size() == 0) begin
      check("sb_empty", 32'(q.size()), 32'd1);
    end else begin
      e = q.pop_front();
      check("anodes", 32'(anodes), 32'(e.an));
      check("segments", 32'(segments), 32'(e.seg));
      check("frame_done", 32'(frame_done), 32'(e.fd));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] mask);
    digits_in  = d;
    dp_in      = dp;
    blank_mask = mask;
    load       = 1'b1;
    step();
    load       = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; load = 1'b0; lz_blank = 1'b0;
    digits_in = '0; dp_in = '0; blank_mask = '0;
    en2 = 1'b0; load2 = 1'b0; lz2 = 1'b0; dig2 = '0; dp2 = 1'b0; mask2 = 1'b0;

    #3;
    check("rst_anodes", 32'(anodes), 32'hF);
    check("rst_segments", 32'(segments), 32'hFF);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    check("rst_an2", 32'(an2), 32'h1);
    check("rst_seg2", 32'(seg2), 32'hFF);
    @(negedge x1);
    rst = 1'b0;

    // Load while dark, then start scanning: two frames of 12AF.
    push_dark(1);
    do_load(16'h12AF, 4'b0000, 4'b0000);
    enable = 1'b1;
    push_frame(16'h12AF, 4'b0000, 4'b0000, 1'b0, 1'b0);
    push_frame(16'h12AF, 4'b0000, 4'b0000, 1'b0, 1'b1);
    run(42);
    lz_blank = 1'b1;
    do_load(16'h0005, 4'b0000, 4'b0000);
    run(21);

    // Leading-zero suppression on, then off.
    push_frame(16'h0005, 4'b0000, 4'b0000, 1'b1, 1'b1);
    push_frame(16'h0005, 4'b0000, 4'b0000, 1'b0, 1'b1);
    run(32);
    run(1);
    lz_blank = 1'b0;
    run(10);
    do_load(16'h1111, 4'b0100, 4'b0100);
    run(20);

    // Mask + DP frame, mid-frame reload, boundary-cycle reload.
    push_frame(16'h1111, 4'b0100, 4'b0100, 1'b0, 1'b1);
    push_frame(16'h2222, 4'b0000, 4'b0000, 1'b0, 1'b1);
    push_frame(16'h2222, 4'b0000, 4'b0000, 1'b0, 1'b1);
    push_frame(16'h3333, 4'b0000, 4'b0000, 1'b0, 1'b1);
    run(12);
    do_load(16'h2222, 4'b0000, 4'b0000);
    run(19);
    run(32);
    do_load(16'h3333, 4'b0000, 4'b0000);
    run(31);

    // Drop enable mid-ON, go dark, restart at slot 0.
    run(20);
    enable = 1'b0;
    q.delete();
    push_dark(3);
    run(3);
    enable = 1'b1;
    push_frame(16'h3333, 4'b0000, 4'b0000, 1'b0, 1'b0);
    push_frame(16'h3333, 4'b0000, 4'b0000, 1'b0, 1'b1);
    run(44);

    // Asynchronous reset mid-slot; pending is lost afterwards.
    q.delete();
    #1 rst = 1'b1;
    #1;
    check("arst_anodes", 32'(anodes), 32'hF);
    check("arst_segments", 32'(segments), 32'hFF);
    check("arst_frame_done", 32'(frame_done), 32'h0);
    @(negedge x1);
    rst = 1'b0;
    push_frame(16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    run(32);

    // Single digit, no dead time: anode held low, digit 0 never LZ-blanked.
    enable = 1'b0;
    lz2 = 1'b1; dig2 = 4'h0; load2 = 1'b1;
    @(negedge x1);
    load2 = 1'b0;
    en2 = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge x1);
      check("d1_anode", 32'(an2), 32'h0);
      check("d1_segments", 32'(seg2), 32'hC0);
      check("d1_frame_done", 32'(fd2), (k > 0 && (k % 5) == 0) ? 32'h1 : 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
